// File: rtl/reg_pkg.sv
// Register-bus request/response types shared by the bridge, the watchdog and the demux.
package reg_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

// File: rtl/reg_wdog_pkg.sv
// Watchdog FSM states, the default error read-data pattern and the error-response builder.
package reg_wdog_pkg;
  import reg_pkg::*;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } reg_wdog_state_e;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADC_AB1E;

  function automatic reg_rsp_t build_err_rsp(input logic [31:0] rdata);
    reg_rsp_t rsp;
    rsp       = '0;
    rsp.rdata = rdata;
    rsp.error = 1'b1;
    rsp.ready = 1'b1;
    return rsp;
  endfunction

endpackage

// File: rtl/reg_bus_watchdog.sv
// Register-bus timeout guard: forwards accesses, aborts ones the peripheral leaves hanging,
// and keeps the abandoned request presented downstream until it finally completes.
module reg_bus_watchdog
  import reg_wdog_pkg::*;
#(
  parameter type         req_t          = reg_pkg::reg_req_t,
  parameter type         rsp_t          = reg_pkg::reg_rsp_t,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  req_t             in_req_i,
  output rsp_t             in_rsp_o,
  output req_t             out_req_o,
  input  rsp_t             out_rsp_i,
  input  logic             clear_i,
  output logic             timeout_o,
  output logic             drain_o,
  output logic [31:0]      err_addr_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int unsigned       WCNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(TIMEOUT_CYCLES);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [CNT_W-1:0]  ECNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  ECNT_ONE  = CNT_W'(1);

  reg_wdog_state_e   state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  req_t              hold_q, hold_d;
  logic [31:0]       err_addr_q, err_addr_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]  err_cnt_base;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      hold_q     <= '0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      hold_q     <= hold_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    hold_d       = hold_q;
    err_addr_d   = err_addr_q;
    err_cnt_d    = err_cnt_q;
    out_req_o    = in_req_i;
    in_rsp_o     = out_rsp_i;
    timeout_o    = 1'b0;
    // An abort in the same cycle as a clear counts from zero, so the abort survives.
    err_cnt_base = clear_i ? '0 : err_cnt_q;

    if (clear_i) begin
      err_addr_d = '0;
      err_cnt_d  = '0;
    end

    unique case (state_q)
      ST_IDLE: begin
        wait_cnt_d = '0;
        if (in_req_i.valid && !out_rsp_i.ready) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WCNT_ONE;
        end
      end

      ST_WAIT: begin
        if (!in_req_i.valid || out_rsp_i.ready) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WCNT_MAX) begin
          in_rsp_o   = build_err_rsp(ERR_RDATA);
          timeout_o  = 1'b1;
          hold_d     = in_req_i;
          err_addr_d = in_req_i.addr;
          err_cnt_d  = (err_cnt_base == ECNT_MAX) ? ECNT_MAX : err_cnt_base + ECNT_ONE;
          state_d    = ST_DRAIN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_ONE;
        end
      end

      ST_DRAIN: begin
        // Keep the abandoned access on the bus; the peripheral's late reply is swallowed.
        out_req_o       = hold_q;
        out_req_o.valid = 1'b1;
        in_rsp_o        = '0;
        if (in_req_i.valid) begin
          in_rsp_o = build_err_rsp(ERR_RDATA);
        end
        if (out_rsp_i.ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  assign drain_o    = (state_q == ST_DRAIN);
  assign err_addr_o = err_addr_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_reg_bus_watchdog.sv
// Directed bench for reg_bus_watchdog with TIMEOUT_CYCLES = 16 and an 8-bit abort counter.
module tb_reg_bus_watchdog;
  import reg_pkg::*;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  reg_req_t    in_req;
  reg_rsp_t    in_rsp;
  reg_req_t    out_req;
  reg_rsp_t    out_rsp;
  logic        clear;
  logic        timeout;
  logic        drain;
  logic [31:0] err_addr;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic prev_wait = 1'b0;

  always #5 clk = ~clk;

  reg_bus_watchdog #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (8)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .in_req_i  (in_req),
    .in_rsp_o  (in_rsp),
    .out_req_o (out_req),
    .out_rsp_i (out_rsp),
    .clear_i   (clear),
    .timeout_o (timeout),
    .drain_o   (drain),
    .err_addr_o(err_addr),
    .err_cnt_o (err_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Upstream master must hold valid while its access is outstanding.
  always @(posedge clk) begin
    if (rst_n && prev_wait) chk("protocol_valid_held", in_req.valid, 1'b1);
    prev_wait = rst_n && in_req.valid && !in_rsp.ready;
  end

  typedef struct {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdy;
    logic        serr;
    logic [31:0] rdata;
    logic        exp_ready;
    logic        exp_error;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [5];

  // Present a request and let it hang until the abort cycle, then leave DRAIN pending.
  task automatic abort_access(input logic [31:0] addr, input logic clr);
    in_req       = '0;
    in_req.valid = 1'b1;
    in_req.addr  = addr;
    out_rsp      = '0;
    repeat (TO) @(posedge clk);
    #1;
    clear = clr;
    @(posedge clk); #1;
    clear  = 1'b0;
    in_req = '0;
  endtask

  task automatic release_drain();
    out_rsp.ready = 1'b1;
    @(posedge clk); #1;
    out_rsp = '0;
  endtask

  initial begin
    in_req = '0;
    out_rsp = '0;
    clear = 1'b0;
    rst_n = 1'b0;

    vecs[0] = '{1'b1, 1'b1, 32'h0000_1234, 32'h0000_DEAD, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b1, 1'b0, 32'h5555_AAAA, 1'b1, 1'b0, 32'h5555_AAAA};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         1'b1, 1'b1, 32'h0,         1'b1, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0024, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0077, 1'b1, 1'b0, 32'h0000_0077};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_drain", drain, 1'b0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_err_cnt", err_cnt, 8'h0);
    chk("rst_in_rsp", in_rsp, '0);
    chk("rst_out_req", out_req, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-cycle accesses pass straight through.
    for (int i = 0; i < 5; i++) begin
      in_req         = '0;
      in_req.valid   = vecs[i].valid;
      in_req.write   = vecs[i].write;
      in_req.addr    = vecs[i].addr;
      in_req.wdata   = vecs[i].wdata;
      in_req.wstrb   = 4'hF;
      out_rsp.ready  = vecs[i].rdy;
      out_rsp.error  = vecs[i].serr;
      out_rsp.rdata  = vecs[i].rdata;
      #1;
      chk($sformatf("vec%0d_ready", i), in_rsp.ready, vecs[i].exp_ready);
      chk($sformatf("vec%0d_error", i), in_rsp.error, vecs[i].exp_error);
      chk($sformatf("vec%0d_rdata", i), in_rsp.rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_out_addr", i), out_req.addr, vecs[i].addr);
      chk($sformatf("vec%0d_out_wdata", i), out_req.wdata, vecs[i].wdata);
      chk($sformatf("vec%0d_out_valid", i), out_req.valid, vecs[i].valid);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_err_cnt", i), err_cnt, 8'h0);
      chk($sformatf("vec%0d_drain", i), drain, 1'b0);
    end
    in_req = '0;
    out_rsp = '0;

    // Slow slave answers in cycle 10.
    in_req.valid = 1'b1;
    in_req.addr  = 32'h0000_0100;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("slow_c%0d_ready", c), in_rsp.ready, 1'b0);
      chk($sformatf("slow_c%0d_timeout", c), timeout, 1'b0);
      @(posedge clk); #1;
    end
    out_rsp.ready = 1'b1;
    out_rsp.rdata = 32'h0000_CAFE;
    #1;
    chk("slow_rdata", in_rsp.rdata, 32'h0000_CAFE);
    chk("slow_error", in_rsp.error, 1'b0);
    chk("slow_ready", in_rsp.ready, 1'b1);
    chk("slow_timeout", timeout, 1'b0);
    @(posedge clk); #1;
    in_req = '0;
    out_rsp = '0;
    chk("slow_drain_after", drain, 1'b0);
    chk("slow_cnt_after", err_cnt, 8'h0);

    // Ready in exactly the abort cycle: normal completion wins.
    in_req.valid = 1'b1;
    in_req.addr  = 32'h0000_0200;
    repeat (TO) @(posedge clk);
    #1;
    out_rsp.ready = 1'b1;
    out_rsp.rdata = 32'h1111_2222;
    #1;
    chk("bound_error", in_rsp.error, 1'b0);
    chk("bound_rdata", in_rsp.rdata, 32'h1111_2222);
    chk("bound_timeout", timeout, 1'b0);
    @(posedge clk); #1;
    in_req = '0;
    out_rsp = '0;
    chk("bound_drain", drain, 1'b0);
    chk("bound_cnt", err_cnt, 8'h0);

    // Hung slave.
    in_req.valid = 1'b1;
    in_req.write = 1'b1;
    in_req.addr  = 32'h3000_0040;
    in_req.wdata = 32'h0000_00AB;
    for (int c = 0; c < TO; c++) begin
      #1;
      chk($sformatf("hung_c%0d_ready", c), in_rsp.ready, 1'b0);
      if (c == TO - 1) chk("hung_c15_timeout", timeout, 1'b0);
      @(posedge clk); #1;
    end
    #1;
    chk("hung_ready", in_rsp.ready, 1'b1);
    chk("hung_error", in_rsp.error, 1'b1);
    chk("hung_rdata", in_rsp.rdata, 32'hBADC_AB1E);
    chk("hung_timeout", timeout, 1'b1);
    @(posedge clk); #1;
    in_req = '0;
    chk("hung_err_addr", err_addr, 32'h3000_0040);
    chk("hung_err_cnt", err_cnt, 8'd1);
    chk("hung_drain", drain, 1'b1);
    chk("hung_timeout_pulse", timeout, 1'b0);

    // Fast-fail while draining.
    in_req.valid = 1'b1;
    in_req.addr  = 32'h3000_0000;
    #1;
    chk("drain_ff_ready", in_rsp.ready, 1'b1);
    chk("drain_ff_error", in_rsp.error, 1'b1);
    chk("drain_ff_rdata", in_rsp.rdata, 32'hBADC_AB1E);
    chk("drain_out_addr", out_req.addr, 32'h3000_0040);
    chk("drain_out_write", out_req.write, 1'b1);
    chk("drain_out_valid", out_req.valid, 1'b1);
    @(posedge clk); #1;
    in_req = '0;
    chk("drain_ff_cnt", err_cnt, 8'd1);
    chk("drain_ff_addr", err_addr, 32'h3000_0040);
    out_rsp.ready = 1'b1;
    out_rsp.rdata = 32'h0000_9999;
    #1;
    chk("drain_discard_ready", in_rsp.ready, 1'b0);
    @(posedge clk); #1;
    out_rsp = '0;
    chk("drain_fall", drain, 1'b0);
    in_req.valid  = 1'b1;
    in_req.addr   = 32'h3000_0008;
    out_rsp.ready = 1'b1;
    out_rsp.rdata = 32'h0000_4242;
    #1;
    chk("post_drain_fwd_addr", out_req.addr, 32'h3000_0008);
    chk("post_drain_rdata", in_rsp.rdata, 32'h0000_4242);
    chk("post_drain_error", in_rsp.error, 1'b0);
    @(posedge clk); #1;
    in_req = '0;
    out_rsp = '0;

    // Abort coincident with clear.
    abort_access(32'h3000_0100, 1'b0);
    release_drain();
    chk("pre_clear_cnt", err_cnt, 8'd2);
    abort_access(32'h3000_0200, 1'b1);
    chk("abort_clear_cnt", err_cnt, 8'd1);
    chk("abort_clear_addr", err_addr, 32'h3000_0200);
    release_drain();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clear_cnt", err_cnt, 8'd0);
    chk("clear_addr", err_addr, 32'h0);

    // Counter saturation.
    for (int i = 0; i < 260; i++) begin
      abort_access(32'h4000_0000 + 32'(i), 1'b0);
      release_drain();
      if (i == 253) chk("sat_cnt_254", err_cnt, 8'd254);
      if (i == 254) chk("sat_cnt_255", err_cnt, 8'd255);
    end
    chk("sat_cnt_final", err_cnt, 8'd255);
    chk("sat_addr_final", err_addr, 32'h4000_0103);

    // Reset while draining.
    abort_access(32'h3000_0300, 1'b0);
    chk("rst_drain_pre", drain, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_drain", drain, 1'b0);
    chk("rst_mid_cnt", err_cnt, 8'h0);
    chk("rst_mid_addr", err_addr, 32'h0);
    chk("rst_mid_timeout", timeout, 1'b0);
    chk("rst_mid_out_req", out_req, '0);
    chk("rst_mid_in_rsp", in_rsp, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_req.valid = 1'b1;
    in_req.addr  = 32'h0000_0044;
    #1;
    chk("post_rst_fwd_addr", out_req.addr, 32'h0000_0044);
    chk("post_rst_drain", drain, 1'b0);
    out_rsp.ready = 1'b1;
    @(posedge clk); #1;
    in_req = '0;
    out_rsp = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
